// File: rtl/mux_n_to_1_reg.sv
// N-to-1 data mux with one registered, back-pressured output stage.
// Out-of-range selects yield zero data, an error-tagged beat, and bump a saturating error counter.
module mux_n_to_1_reg #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_IN  = 4,
   parameter int unsigned SEL_W = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_IN*WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err_flag,
   input  logic                    err_clr,
   output logic [7:0]              err_cnt
);

   // Compare width wide enough for both sel and N_IN (N_IN <= 16), so sel is never truncated
   localparam int unsigned CMP_W = (SEL_W > 5) ? SEL_W : 5;
   localparam int unsigned CNT_W = 8;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_err_q, out_err_d;
   logic             out_valid_q, out_valid_d;
   logic             err_flag_q, err_flag_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [WIDTH-1:0] sel_data;
   logic             in_range;
   logic             accept;
   logic             err_beat;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign in_range = CMP_W'(sel) < CMP_W'(N_IN);
   assign err_beat = accept && !in_range;

   // Data select; defaults to zero so an out-of-range sel never yields X
   always_comb begin
      sel_data = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (CMP_W'(sel) == CMP_W'(k)) begin
            sel_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      out_valid_d = out_valid_q;
      err_flag_d  = err_flag_q;
      err_cnt_d   = err_cnt_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = in_range ? sel_data : '0;
         out_err_d   = !in_range;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // An error beat wins over a same-cycle clear
      if (err_beat) begin
         err_flag_d = 1'b1;
         if (err_clr) begin
            err_cnt_d = CNT_W'(1);
         end else if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
      end else if (err_clr) begin
         err_flag_d = 1'b0;
         err_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
         err_flag_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         out_valid_q <= out_valid_d;
         err_flag_q  <= err_flag_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_err   = out_err_q;
   assign out_valid = out_valid_q;
   assign err_flag  = err_flag_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Scoreboard bench for mux_n_to_1_reg (WIDTH=32, N_IN=3, SEL_W=2).
module tb_mux_n_to_1_reg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned N_IN  = 3;
   localparam int unsigned SEL_W = 2;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]      sel;
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_err;
   logic                  out_valid;
   logic                  out_ready;
   logic                  err_flag;
   logic                  err_clr;
   logic [7:0]            err_cnt;

   mux_n_to_1_reg #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
      .out_ready(out_ready), .err_flag(err_flag), .err_clr(err_clr), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [WIDTH-1:0] din [N_IN];
   beat_t            sb_q [$];
   logic             m_valid = 1'b0;
   logic [WIDTH-1:0] m_data  = '0;
   logic             m_err   = 1'b0;
   logic             m_flag  = 1'b0;
   logic [7:0]       m_cnt   = '0;

   task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, check handshake and consumed beat, advance model, check state
   task automatic cycle(input logic r, input logic iv, input logic [SEL_W-1:0] s,
                        input logic ordy, input logic clr);
      logic  m_ready, acc, cons;
      beat_t exp_b;
      rst = r; in_valid = iv; sel = s; out_ready = ordy; err_clr = clr;
      in_data = {din[2], din[1], din[0]};
      #1;
      m_ready = !m_valid || ordy;
      check("in_ready", WIDTH'(in_ready), WIDTH'(m_ready));
      acc  = !r && iv && m_ready;
      cons = !r && m_valid && ordy;
      if (cons) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_b = sb_q.pop_front();
            check("sb_data", out_data, exp_b.data);
            check("sb_err", WIDTH'(out_err), WIDTH'(exp_b.err));
         end
      end
      @(posedge clk);
      if (r) begin
         m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_flag = 1'b0; m_cnt = '0;
         sb_q.delete();
      end else begin
         if (acc) begin
            exp_b.err  = (int'(s) >= int'(N_IN));
            exp_b.data = exp_b.err ? '0 : din[s];
            sb_q.push_back(exp_b);
            m_data = exp_b.data;
            m_err  = exp_b.err;
         end
         m_valid = acc || (m_valid && !cons);
         if (acc && int'(s) >= int'(N_IN)) begin
            m_flag = 1'b1;
            m_cnt  = clr ? 8'd1 : (m_cnt == 8'hFF ? 8'hFF : m_cnt + 8'd1);
         end else if (clr) begin
            m_flag = 1'b0;
            m_cnt  = '0;
         end
      end
      @(negedge clk);
      check("out_valid", WIDTH'(out_valid), WIDTH'(m_valid));
      check("out_data", out_data, m_data);
      check("out_err", WIDTH'(out_err), WIDTH'(m_err));
      check("err_flag", WIDTH'(err_flag), WIDTH'(m_flag));
      check("err_cnt", WIDTH'(err_cnt), WIDTH'(m_cnt));
   endtask

   initial begin
      din[0] = 32'h11111111; din[1] = 32'h22222222; din[2] = 32'h33333333;
      rst = 1'b1; in_valid = 1'b0; sel = '0; out_ready = 1'b0; err_clr = 1'b0;
      in_data = '0;
      @(posedge clk);
      @(negedge clk);

      // Reset state
      cycle(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
      check("rst_in_ready", WIDTH'(in_ready), 32'd1);
      check("rst_out_data", out_data, 32'h0);

      // Single in-range beat, sel=1
      cycle(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
      check("beat_b", out_data, 32'h22222222);

      // Back-to-back beats, no bubbles
      cycle(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
      check("b2b_a", out_data, 32'h11111111);
      cycle(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
      check("b2b_b", out_data, 32'h22222222);
      cycle(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
      check("b2b_c", out_data, 32'h33333333);
      check("b2b_valid", WIDTH'(out_valid), 32'd1);

      // Backpressure: C held while sel=0 offered
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
         check("hold_c", out_data, 32'h33333333);
      end
      cycle(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
      check("release_a", out_data, 32'h11111111);
      cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      check("drain_valid", WIDTH'(out_valid), 32'd0);
      check("drain_data_kept", out_data, 32'h11111111);

      // Out-of-range beat and counter saturation
      cycle(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
      check("oor_data", out_data, 32'h0);
      check("oor_err", WIDTH'(out_err), 32'd1);
      check("oor_cnt1", WIDTH'(err_cnt), 32'd1);
      for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
      check("oor_sat", WIDTH'(err_cnt), 32'd255);
      check("oor_flag", WIDTH'(err_flag), 32'd1);

      // Error beat beats clear, then plain clear
      cycle(1'b0, 1'b1, 2'd3, 1'b1, 1'b1);
      check("clr_prio_cnt", WIDTH'(err_cnt), 32'd1);
      cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
      check("clr_cnt", WIDTH'(err_cnt), 32'd0);
      check("clr_flag", WIDTH'(err_flag), 32'd0);

      // Reset while stalled with a held beat and input offered
      cycle(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
      check("rst_hold_valid", WIDTH'(out_valid), 32'd0);
      check("rst_hold_data", out_data, 32'h0);
      check("rst_hold_ready", WIDTH'(in_ready), 32'd1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) din[$urandom_range(0, 2)] = $urandom;
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
               SEL_W'($urandom_range(0, 3)), ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
